// File: rtl/axi_wr_arbiter.sv
// Two-master round-robin arbiter for the AXI3 write channels (AW/W/B).
// One burst is granted at a time and W stays locked to the winner until WLAST.
module axi_wr_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,

  input  logic [2*ID_W-1:0]       m_awid,
  input  logic [2*ADDR_W-1:0]     m_awaddr,
  input  logic [25:0]             m_awattr,
  input  logic [1:0]              m_awvalid,
  output logic [1:0]              m_awready,

  input  logic [2*DATA_W-1:0]     m_wdata,
  input  logic [2*(DATA_W/8)-1:0] m_wstrb,
  input  logic [1:0]              m_wlast,
  input  logic [1:0]              m_wvalid,
  output logic [1:0]              m_wready,

  output logic [ID_W-1:0]         m_bid,
  output logic [1:0]              m_bresp,
  output logic [1:0]              m_bvalid,
  input  logic [1:0]              m_bready,

  output logic [ID_W:0]           s_awid,
  output logic [ADDR_W-1:0]       s_awaddr,
  output logic [12:0]             s_awattr,
  output logic                    s_awvalid,
  input  logic                    s_awready,

  output logic [ID_W:0]           s_wid,
  output logic [DATA_W-1:0]       s_wdata,
  output logic [DATA_W/8-1:0]     s_wstrb,
  output logic                    s_wlast,
  output logic                    s_wvalid,
  input  logic                    s_wready,

  input  logic [ID_W:0]           s_bid,
  input  logic [1:0]              s_bresp,
  input  logic                    s_bvalid,
  output logic                    s_bready
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t          state_q, state_d;
  logic            grant_q, grant_d;
  logic            prio_q, prio_d;
  logic [ID_W:0]   wid_q;
  logic [ID_W-1:0] g_awid;
  logic            aw_fire;
  logic            b_sel;

  // Everything on the slave side follows the registered grant, so the
  // s_*valid outputs never depend on s_*ready.
  assign g_awid   = grant_q ? m_awid[2*ID_W-1:ID_W]       : m_awid[ID_W-1:0];
  assign s_awid   = {grant_q, g_awid};
  assign s_awaddr = grant_q ? m_awaddr[2*ADDR_W-1:ADDR_W] : m_awaddr[ADDR_W-1:0];
  assign s_awattr = grant_q ? m_awattr[25:13]             : m_awattr[12:0];
  assign s_wdata  = grant_q ? m_wdata[2*DATA_W-1:DATA_W]  : m_wdata[DATA_W-1:0];
  assign s_wstrb  = grant_q ? m_wstrb[2*STRB_W-1:STRB_W]  : m_wstrb[STRB_W-1:0];
  assign s_wlast  = grant_q ? m_wlast[1]                  : m_wlast[0];
  assign s_wid    = wid_q;
  assign aw_fire  = s_awvalid & s_awready;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    prio_d    = prio_q;
    s_awvalid = 1'b0;
    m_awready = 2'b00;
    s_wvalid  = 1'b0;
    m_wready  = 2'b00;
    case (state_q)
      IDLE: begin
        if (m_awvalid != 2'b00) begin
          state_d = ADDR;
          grant_d = (m_awvalid == 2'b11) ? prio_q : m_awvalid[1];
        end
      end
      ADDR: begin
        s_awvalid          = m_awvalid[grant_q];
        m_awready[grant_q] = s_awready;
        if (m_awvalid[grant_q] && s_awready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        s_wvalid          = m_wvalid[grant_q];
        m_wready[grant_q] = s_wready;
        if (m_wvalid[grant_q] && s_wready && s_wlast) begin
          state_d = IDLE;
          prio_d  = ~grant_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      prio_q  <= 1'b0;
      wid_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      if (aw_fire) begin
        wid_q <= s_awid;
      end
    end
  end

  // Responses are steered by the ID MSB and are gated off while in reset.
  assign b_sel    = s_bid[ID_W];
  assign m_bid    = s_bid[ID_W-1:0];
  assign m_bresp  = s_bresp;
  assign m_bvalid = aresetn ? {b_sel & s_bvalid, ~b_sel & s_bvalid} : 2'b00;
  assign s_bready = aresetn & m_bready[b_sel];

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Scoreboard bench for axi_wr_arbiter: bus-functional masters push expected
// bursts, a negedge monitor predicts the grant order and checks the slave side.
module tb_axi_wr_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int STRB_W = DATA_W / 8;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [12:0]       attr;
  } aw_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } w_t;

  logic                    aclk;
  logic                    aresetn;
  logic [2*ID_W-1:0]       m_awid;
  logic [2*ADDR_W-1:0]     m_awaddr;
  logic [25:0]             m_awattr;
  logic [1:0]              m_awvalid;
  logic [1:0]              m_awready;
  logic [2*DATA_W-1:0]     m_wdata;
  logic [2*STRB_W-1:0]     m_wstrb;
  logic [1:0]              m_wlast;
  logic [1:0]              m_wvalid;
  logic [1:0]              m_wready;
  logic [ID_W-1:0]         m_bid;
  logic [1:0]              m_bresp;
  logic [1:0]              m_bvalid;
  logic [1:0]              m_bready;
  logic [ID_W:0]           s_awid;
  logic [ADDR_W-1:0]       s_awaddr;
  logic [12:0]             s_awattr;
  logic                    s_awvalid;
  logic                    s_awready;
  logic [ID_W:0]           s_wid;
  logic [DATA_W-1:0]       s_wdata;
  logic [STRB_W-1:0]       s_wstrb;
  logic                    s_wlast;
  logic                    s_wvalid;
  logic                    s_wready;
  logic [ID_W:0]           s_bid;
  logic [1:0]              s_bresp;
  logic                    s_bvalid;
  logic                    s_bready;

  logic [ID_W-1:0]   awid_d   [2];
  logic [ADDR_W-1:0] awaddr_d [2];
  logic [12:0]       awattr_d [2];
  logic              awvalid_d[2];
  logic [DATA_W-1:0] wdata_d  [2];
  logic [STRB_W-1:0] wstrb_d  [2];
  logic              wlast_d  [2];
  logic              wvalid_d [2];

  assign m_awid    = {awid_d[1], awid_d[0]};
  assign m_awaddr  = {awaddr_d[1], awaddr_d[0]};
  assign m_awattr  = {awattr_d[1], awattr_d[0]};
  assign m_awvalid = {awvalid_d[1], awvalid_d[0]};
  assign m_wdata   = {wdata_d[1], wdata_d[0]};
  assign m_wstrb   = {wstrb_d[1], wstrb_d[0]};
  assign m_wlast   = {wlast_d[1], wlast_d[0]};
  assign m_wvalid  = {wvalid_d[1], wvalid_d[0]};

  axi_wr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awattr(m_awattr),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awattr(s_awattr),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  int   n_vec = 0;
  int   n_err = 0;
  aw_t  exp_aw[2][$];
  w_t   exp_w[2][$];

  // Reference view of the shared bus: who owns it and who gets the next tie.
  logic          bus_busy;
  logic          aw_done;
  logic          first_addr;
  logic          ptr;
  logic          exp_m;
  logic          other;
  logic [ID_W:0] exp_wid;

  bit abort;
  bit stall_mode;
  bit b_force;
  int cyc;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #500us;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full burst on master m: AW and first W beat are offered together.
  task automatic applyStimulus(input int m, input logic [ID_W-1:0] id,
                               input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                               input logic [DATA_W-1:0] base, input bit gaps);
    w_t  beats[$];
    aw_t a;
    int  beat;
    int  budget;
    bit  aw_hs;
    bit  w_hs;
    a.id   = id;
    a.addr = addr;
    a.attr = {2'b01, 3'b010, len};
    exp_aw[m].push_back(a);
    for (int i = 0; i <= int'(len); i++) begin
      w_t w;
      w.data = base + DATA_W'(i);
      w.strb = gaps ? STRB_W'($urandom) : '1;
      w.last = (i == int'(len));
      beats.push_back(w);
      exp_w[m].push_back(w);
    end
    awid_d[m]    = id;
    awaddr_d[m]  = addr;
    awattr_d[m]  = a.attr;
    awvalid_d[m] = 1'b1;
    wdata_d[m]   = beats[0].data;
    wstrb_d[m]   = beats[0].strb;
    wlast_d[m]   = beats[0].last;
    wvalid_d[m]  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
    beat   = 0;
    budget = 0;
    while (beat <= int'(len)) begin
      @(negedge aclk);
      aw_hs = awvalid_d[m] && m_awready[m];
      w_hs  = wvalid_d[m] && m_wready[m];
      @(posedge aclk);
      #1;
      if (abort) begin
        awvalid_d[m] = 1'b0;
        wvalid_d[m]  = 1'b0;
        return;
      end
      if (aw_hs) awvalid_d[m] = 1'b0;
      if (w_hs) begin
        beat++;
        wvalid_d[m] = 1'b0;
      end
      if (beat <= int'(len)) begin
        wdata_d[m] = beats[beat].data;
        wstrb_d[m] = beats[beat].strb;
        wlast_d[m] = beats[beat].last;
        if (!wvalid_d[m]) wvalid_d[m] = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      budget++;
      if (budget > 3000) begin
        checkOutput("burst_timeout", 64'(0), 64'(1));
        break;
      end
    end
    awvalid_d[m] = 1'b0;
    wvalid_d[m]  = 1'b0;
  endtask

  // Slave side and B-channel drivers.
  initial begin
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_bid     = '0;
    s_bresp   = 2'b00;
    m_bready  = 2'b00;
    cyc       = 0;
    forever begin
      @(posedge aclk);
      #1;
      cyc++;
      if (stall_mode) begin
        s_awready = (cyc % 7) >= 5;
        s_wready  = 1'($urandom_range(0, 1));
      end else begin
        s_awready = 1'b1;
        s_wready  = 1'b1;
      end
      if (b_force) begin
        s_bvalid = 1'b1;
        s_bid    = {1'b1, 4'h5};
        s_bresp  = 2'b00;
      end else begin
        s_bvalid = 1'($urandom_range(0, 1));
        s_bid    = (ID_W+1)'($urandom);
        s_bresp  = 2'($urandom);
      end
      m_bready = 2'($urandom);
    end
  end

  // Monitor: predicts arbitration and pops expected traffic on handshakes.
  initial begin
    logic       bidx;
    logic [1:0] expb;
    aw_t        a;
    w_t         w;
    bus_busy   = 1'b0;
    aw_done    = 1'b0;
    first_addr = 1'b0;
    ptr        = 1'b0;
    exp_m      = 1'b0;
    other      = 1'b1;
    exp_wid    = '0;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        bidx = s_bid[ID_W];
        expb = s_bvalid ? (bidx ? 2'b10 : 2'b01) : 2'b00;
        checkOutput("b_valid_route", 64'(m_bvalid), 64'(expb));
        if (s_bvalid) begin
          checkOutput("b_ready_route", 64'(s_bready), 64'(m_bready[bidx]));
          checkOutput("b_id_resp", 64'({m_bid, m_bresp}), 64'({s_bid[ID_W-1:0], s_bresp}));
        end
        if (!bus_busy) begin
          checkOutput("idle_quiet", 64'({s_awvalid, s_wvalid, m_awready, m_wready}), 64'(0));
          if (m_awvalid != 2'b00) begin
            exp_m      = (m_awvalid == 2'b11) ? ptr : m_awvalid[1];
            other      = ~exp_m;
            bus_busy   = 1'b1;
            aw_done    = 1'b0;
            first_addr = 1'b1;
          end
        end else if (!aw_done) begin
          if (first_addr) begin
            checkOutput("grant_latency", 64'({s_awvalid, s_awid[ID_W]}), 64'({1'b1, exp_m}));
            first_addr = 1'b0;
          end
          checkOutput("addr_gating", 64'({m_awready[other], m_wready, s_wvalid}), 64'(0));
          checkOutput("awready_route", 64'(m_awready[exp_m]), 64'(s_awready));
          if (s_awvalid && s_awready) begin
            if (exp_aw[exp_m].size() == 0) begin
              checkOutput("aw_unexpected", 64'(1), 64'(0));
            end else begin
              a = exp_aw[exp_m].pop_front();
              checkOutput("aw_id", 64'(s_awid), 64'({exp_m, a.id}));
              checkOutput("aw_addr", 64'(s_awaddr), 64'(a.addr));
              checkOutput("aw_attr", 64'(s_awattr), 64'(a.attr));
              exp_wid = {exp_m, a.id};
            end
            aw_done = 1'b1;
          end
        end else begin
          checkOutput("data_gating", 64'({s_awvalid, m_awready, m_wready[other]}), 64'(0));
          checkOutput("wvalid_route", 64'({s_wvalid, m_wready[exp_m]}),
                      64'({m_wvalid[exp_m], s_wready}));
          if (s_wvalid && s_wready) begin
            if (exp_w[exp_m].size() == 0) begin
              checkOutput("w_unexpected", 64'(1), 64'(0));
            end else begin
              w = exp_w[exp_m].pop_front();
              checkOutput("w_data", 64'(s_wdata), 64'(w.data));
              checkOutput("w_strb_last", 64'({s_wstrb, s_wlast}), 64'({w.strb, w.last}));
              checkOutput("w_id", 64'(s_wid), 64'(exp_wid));
              if (w.last) begin
                bus_busy = 1'b0;
                ptr      = other;
              end
            end
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      awid_d[i] = '0;  awaddr_d[i] = '0; awattr_d[i] = '0; awvalid_d[i] = 1'b0;
      wdata_d[i] = '0; wstrb_d[i] = '0;  wlast_d[i] = 1'b0; wvalid_d[i] = 1'b0;
    end
    abort      = 1'b0;
    stall_mode = 1'b0;
    b_force    = 1'b1;
    aresetn    = 1'b0;
    repeat (3) @(posedge aclk);
    #2;
    checkOutput("reset_outputs", 64'({s_awvalid, s_wvalid, m_awready, m_wready, m_bvalid, s_bready}), 64'(0));
    checkOutput("reset_wid", 64'(s_wid), 64'(0));
    aresetn = 1'b1;
    b_force = 1'b0;
    @(posedge aclk);
    #1;

    $display("[TB] dual request after reset, twice");
    fork
      applyStimulus(0, 4'h1, 32'h100, 8'd1, 32'hB0, 1'b0);
      applyStimulus(1, 4'h2, 32'h200, 8'd2, 32'hC0, 1'b0);
    join
    fork
      applyStimulus(0, 4'h3, 32'h140, 8'd2, 32'hB8, 1'b0);
      applyStimulus(1, 4'h4, 32'h240, 8'd1, 32'hC8, 1'b0);
    join

    $display("[TB] master 0 single burst with B traffic for master 1");
    b_force = 1'b1;
    applyStimulus(0, 4'h6, 32'h10, 8'd3, 32'hA0, 1'b0);
    b_force = 1'b0;

    $display("[TB] slave stalls");
    stall_mode = 1'b1;
    applyStimulus(0, 4'h7, 32'h300, 8'd3, 32'hD0, 1'b0);

    $display("[TB] randomized traffic");
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          repeat ($urandom_range(0, 4)) @(posedge aclk);
          #1;
          applyStimulus(0, 4'($urandom), ADDR_W'($urandom), 8'($urandom_range(0, 7)),
                        DATA_W'($urandom), 1'b1);
        end
      end
      begin
        for (int j = 0; j < 12; j++) begin
          repeat ($urandom_range(0, 4)) @(posedge aclk);
          #1;
          applyStimulus(1, 4'($urandom), ADDR_W'($urandom), 8'($urandom_range(0, 7)),
                        DATA_W'($urandom), 1'b1);
        end
      end
    join
    stall_mode = 1'b0;
    applyStimulus(0, 4'h8, 32'h400, 8'd0, 32'hE0, 1'b0);

    $display("[TB] reset mid-DATA");
    b_force = 1'b1;
    fork
      applyStimulus(0, 4'h9, 32'h500, 8'd7, 32'hF0, 1'b0);
      begin
        for (int k = 0; k < 200 && !(bus_busy && aw_done); k++) @(negedge aclk);
        repeat (2) @(negedge aclk);
        checkOutput("reached_data", 64'(bus_busy && aw_done), 64'(1));
        #2;
        aresetn = 1'b0;
        abort   = 1'b1;
        #1;
        checkOutput("midreset_outputs",
                    64'({s_awvalid, s_wvalid, m_awready, m_wready, m_bvalid, s_bready}), 64'(0));
        checkOutput("midreset_wid", 64'(s_wid), 64'(0));
      end
    join
    for (int i = 0; i < 2; i++) begin
      exp_aw[i].delete();
      exp_w[i].delete();
    end
    bus_busy = 1'b0;
    aw_done  = 1'b0;
    ptr      = 1'b0;
    b_force  = 1'b0;
    repeat (2) @(posedge aclk);
    #3;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    abort = 1'b0;
    fork
      applyStimulus(0, 4'hA, 32'h600, 8'd1, 32'h11, 1'b0);
      applyStimulus(1, 4'hB, 32'h700, 8'd1, 32'h22, 1'b0);
    join

    repeat (2) @(posedge aclk);
    #1;
    checkOutput("scoreboard_drain",
                64'(exp_aw[0].size() + exp_aw[1].size() + exp_w[0].size() + exp_w[1].size()),
                64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview: Two-master round-robin arbiter sharing the write channels (AW/W/B) of the single AXI3 slave memory `axi_module`. It grants one master per burst and locks the W channel to that master until WLAST. Write responses are routed back using the master index carried in the ID MSB. It sits between the bus-functional masters and the slave in the verification top.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width; strobe width is DATA_W/8.
ID_W, 4, master-side ID width; slave-side ID width is ID_W+1.

Ports:
aclk  in  1  clock.
aresetn  in  1  asynchronous active-low reset.
m_awid  in  2*ID_W  per-master AWID; master i at [i*ID_W +: ID_W].
m_awaddr  in  2*ADDR_W  per-master AWADDR.
m_awattr  in  2*13  per-master {awburst[1:0], awsize[2:0], awlen[7:0]}.
m_awvalid  in  2  per-master AWVALID.
m_awready  out  2  per-master AWREADY.
m_wdata  in  2*DATA_W  per-master WDATA.
m_wstrb  in  2*DATA_W/8  per-master WSTRB.
m_wlast  in  2  per-master WLAST.
m_wvalid  in  2  per-master WVALID.
m_wready  out  2  per-master WREADY.
m_bid  out  ID_W  BID to masters (slave BID without MSB).
m_bresp  out  2  BRESP to masters.
m_bvalid  out  2  per-master BVALID.
m_bready  in  2  per-master BREADY.
s_awid  out  ID_W+1  {grant index, granted AWID}.
s_awaddr  out  ADDR_W  granted AWADDR.
s_awattr  out  13  granted attributes, same packing as m_awattr.
s_awvalid  out  1  AWVALID to slave.
s_awready  in  1  AWREADY from slave.
s_wid  out  ID_W+1  registered s_awid of the current burst.
s_wdata  out  DATA_W  granted WDATA.
s_wstrb  out  DATA_W/8  granted WSTRB.
s_wlast  out  1  granted WLAST.
s_wvalid  out  1  WVALID to slave.
s_wready  in  1  WREADY from slave.
s_bid  in  ID_W+1  BID from slave.
s_bresp  in  2  BRESP from slave.
s_bvalid  in  1  BVALID from slave.
s_bready  out  1  BREADY to slave.

Behaviour:
- Reset (aresetn low, asynchronous, any state, including mid-burst): state IDLE, grant 0, priority pointer gives master 0 first pick, s_wid 0, and every valid/ready output 0.
- IDLE state:
  - Sample m_awvalid. If no request, stay in IDLE.
  - If exactly one master requests, register grant to it.
  - If both request, grant the master named by the priority pointer.
  - Go to ADDR on the next edge. There is 1 cycle of arbitration latency.
- ADDR state:
  - s_aw* is a combinational mux of the granted master.
  - m_awready[g] = s_awready; the other master's awready is 0.
  - On the s_awvalid && s_awready edge: register s_wid = s_awid, go to DATA.
  - A granted master deasserting awvalid before the handshake is a protocol violation. The arbiter holds the grant regardless.
- DATA state:
  - s_wvalid = m_wvalid[g]; m_wready[g] = s_wready; the other master's wready is 0.
  - The AW channel is closed: s_awvalid 0 and both m_awready 0.
  - On the handshake with s_wlast = 1: go to IDLE and set the priority pointer to the master that was not just served.
  - Beat counts are not checked against awlen; WLAST alone ends the burst.
- IDLE/ADDR/DATA: both m_wready are 0 outside DATA. Write data issued before its AW is not accepted (no W-before-AW support). A new AW can be granted 1 cycle after WLAST.
- B path (combinational, independent of the FSM):
  - m_bvalid[s_bid[ID_W]] = s_bvalid; m_bid = s_bid[ID_W-1:0]; m_bresp = s_bresp.
  - s_bready = m_bready[s_bid[ID_W]].
  - B responses may overlap the next burst's AW/W phases.
- There are no combinational paths from s_*ready to s_*valid.

Test Plan:
- Master 0 only, awaddr 0x10, awlen 3, 4 beats 0xA0..0xA3: s_awid = 0x0_{id}, grant visible 1 cycle after request, 4 beats forwarded, s_wlast on beat 4, IDLE the next cycle.
- Both masters request in the same cycle after reset: master 0 served first, master 1 next; repeat the dual request and master 0 wins again (pointer alternates each time).
- Master 1 holds wvalid during master 0's burst: m_wready[1] stays 0 throughout; master 1's data reaches the slave only after its own AW handshake.
- Slave returns bid = {1, 4'h5}, bresp OKAY while master 0's burst is active: m_bvalid = 2'b10, m_bid = 5, and the W traffic continues unstalled.
- Slave stalls: s_awready low 5 cycles, s_wready toggling: data and valid are held stable and no beat is dropped or duplicated.
- aresetn pulsed low mid-DATA: all valid/ready outputs are 0 immediately, and after release a fresh request from master 0 wins arbitration.
